// File: rtl/usb_bulk_in_sched.sv
// usb_bulk_in_sched: routes one bulk-IN source to the transfer FSM and commits or rewinds it on the host handshake
module usb_bulk_in_sched #(
  parameter int NUM_EP  = 2,
  parameter int EP_BASE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            blk_xfer_endpoint_i,
  input  logic                  blk_in_xfer_i,
  input  logic                  rx_trn_hsk_recv_i,
  input  logic [1:0]            rx_trn_hsk_type_i,
  input  logic [NUM_EP-1:0]     ep_halt_i,
  input  logic [NUM_EP-1:0]     s_has_data_i,
  input  logic [NUM_EP-1:0]     s_tvalid_i,
  input  logic [NUM_EP-1:0]     s_tlast_i,
  input  logic [8*NUM_EP-1:0]   s_tdata_i,
  output logic [NUM_EP-1:0]     s_tready_o,
  output logic [NUM_EP-1:0]     s_commit_o,
  output logic [NUM_EP-1:0]     s_rewind_o,
  output logic                  bid_has_data_o,
  output logic                  bid_tvalid_o,
  output logic                  bid_tlast_o,
  output logic [7:0]            bid_tdata_o,
  input  logic                  bid_tready_i
);
  localparam int SW = NUM_EP > 1 ? $clog2(NUM_EP) : 1;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_HSK} state_t;
  state_t state;
  logic [SW-1:0] sel;
  logic sel_valid, xfer_q, in_range, send, rise, fall, last_beat, ack;
  logic [3:0] idx;
  logic [15:0] has_pad, halt_pad;
  logic [NUM_EP-1:0] sel_oh;
  assign idx = blk_xfer_endpoint_i - 4'(EP_BASE);
  assign in_range = {1'b0, blk_xfer_endpoint_i} >= 5'(EP_BASE) && {1'b0, blk_xfer_endpoint_i} < 5'(EP_BASE + NUM_EP);
  assign has_pad = 16'(s_has_data_i);
  assign halt_pad = 16'(ep_halt_i);
  assign bid_has_data_o = in_range & has_pad[idx] & ~halt_pad[idx];
  assign send = state == SEND && sel_valid;
  assign sel_oh = NUM_EP'(1) << sel;
  assign s_tready_o = send && bid_tready_i ? sel_oh : '0;
  assign bid_tvalid_o = send & s_tvalid_i[sel];
  assign bid_tlast_o = send & s_tlast_i[sel];
  assign bid_tdata_o = send ? s_tdata_i[8*sel +: 8] : 8'h00;
  assign rise = blk_in_xfer_i & ~xfer_q;
  assign fall = ~blk_in_xfer_i & xfer_q;
  assign last_beat = bid_tvalid_o & bid_tready_i & bid_tlast_o;
  assign ack = rx_trn_hsk_recv_i && rx_trn_hsk_type_i == 2'b00;
  // transaction FSM: latch the source on a qualifying rise, finish on handshake or host timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      sel_valid <= 1'b0;
      xfer_q <= 1'b0;
      s_commit_o <= '0;
      s_rewind_o <= '0;
    end else begin
      xfer_q <= blk_in_xfer_i;
      s_commit_o <= '0;
      s_rewind_o <= '0;
      if (state == IDLE) begin
        if (rise && bid_has_data_o) begin
          state <= SEND;
          sel <= idx[SW-1:0];
          sel_valid <= 1'b1;
        end
      end else if (rx_trn_hsk_recv_i || fall) begin
        s_commit_o <= ack ? sel_oh : '0;
        s_rewind_o <= ack ? '0 : sel_oh;
        state <= IDLE;
        sel_valid <= 1'b0;
      end else if (last_beat) begin
        state <= WAIT_HSK;
      end
    end
  end
endmodule

// File: tb/tb_usb_bulk_in_sched.sv
// tb_usb_bulk_in_sched: vector table, directed corner sequences and random traffic against a transaction-level model
module tb_usb_bulk_in_sched;
  localparam int N = 2;
  localparam int B = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] ep = '0;
  logic xfer = 1'b0, hsk = 1'b0, btr = 1'b0;
  logic [1:0] htype = '0, halt = '0, has = '0, tvalid, tlast, tready, commit, rewind;
  logic [15:0] tdata;
  logic bhd, btv, btl;
  logic [7:0] btd;
  int checks = 0, errors = 0;
  logic [7:0] pkt [N][8];
  int len [N], ptr [N];
  bit m_active = 0, m_sent_last = 0, m_prev = 0;
  int m_cur = 0;
  logic [N-1:0] m_cmt = '0, m_rew = '0;
  logic [7:0] fwd [$];
  int beats, cmt_cnt, rew_cnt;
  bit rdy0_seen, rdy_any;

  typedef struct {
    logic [3:0] ep;
    logic [1:0] has;
    logic [1:0] halt;
    logic       exp;
  } vec_t;
  vec_t tv [9];

  usb_bulk_in_sched #(.NUM_EP(N), .EP_BASE(B)) dut (
    .clk(clk), .rst_n(rst_n), .blk_xfer_endpoint_i(ep), .blk_in_xfer_i(xfer),
    .rx_trn_hsk_recv_i(hsk), .rx_trn_hsk_type_i(htype), .ep_halt_i(halt),
    .s_has_data_i(has), .s_tvalid_i(tvalid), .s_tlast_i(tlast), .s_tdata_i(tdata),
    .s_tready_o(tready), .s_commit_o(commit), .s_rewind_o(rewind),
    .bid_has_data_o(bhd), .bid_tvalid_o(btv), .bid_tlast_o(btl), .bid_tdata_o(btd),
    .bid_tready_i(btr)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic clr();
    fwd.delete();
    beats = 0; cmt_cnt = 0; rew_cnt = 0; rdy0_seen = 0; rdy_any = 0;
  endtask

  task automatic set_pkt(input int i, input logic [7:0] base);
    len[i] = 4; ptr[i] = 0;
    for (int j = 0; j < 4; j++) pkt[i][j] = base + 8'(j);
  endtask

  task automatic new_pkt(input int i);
    len[i] = $urandom_range(1, 6); ptr[i] = 0;
    for (int j = 0; j < 8; j++) pkt[i][j] = 8'($urandom);
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      tvalid[i] = ptr[i] < len[i];
      tlast[i] = ptr[i] == len[i] - 1;
      tdata[8*i +: 8] = ptr[i] < len[i] ? pkt[i][ptr[i]] : 8'h00;
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_sent_last = 0; m_prev = 0; m_cmt = '0; m_rew = '0;
    for (int i = 0; i < N; i++) ptr[i] = 0;
  endtask

  // one clock: check outputs mid-cycle, then advance sources and model across the rising edge
  task automatic step();
    bit in_r, ehd, ev, rise, fall;
    int ix;
    logic [N-1:0] rdy, tvs, tls;
    drive_src();
    #1;
    in_r = ep >= 4'(B) && ep < 4'(B + N);
    ix = int'(ep) - B;
    ehd = in_r ? (has[ix] && !halt[ix]) : 1'b0;
    chk("has_data", bhd, ehd);
    ev = m_active && !m_sent_last && tvalid[m_cur];
    chk("tvalid", btv, ev);
    chk("tready", tready, (m_active && !m_sent_last && btr) ? N'(1) << m_cur : N'(0));
    if (ev) begin
      chk("tdata", btd, pkt[m_cur][ptr[m_cur]]);
      chk("tlast", btl, tlast[m_cur]);
    end
    chk("commit", commit, m_cmt);
    chk("rewind", rewind, m_rew);
    if (btv && btr) begin fwd.push_back(btd); beats++; end
    rdy0_seen |= tready[0];
    rdy_any |= |tready;
    cmt_cnt += $countones(commit);
    rew_cnt += $countones(rewind);
    rdy = tready; tvs = tvalid; tls = tlast;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && tvs[i]) ptr[i]++;
      if (m_cmt[i]) new_pkt(i);
      if (m_rew[i]) ptr[i] = 0;
    end
    rise = xfer && !m_prev;
    fall = !xfer && m_prev;
    m_cmt = '0; m_rew = '0;
    if (!m_active) begin
      if (rise && ehd) begin m_active = 1; m_cur = ix; m_sent_last = 0; end
    end else if (hsk) begin
      if (htype == 2'b00) m_cmt[m_cur] = 1'b1; else m_rew[m_cur] = 1'b1;
      m_active = 0;
    end else if (fall) begin
      m_rew[m_cur] = 1'b1;
      m_active = 0;
    end else if (ev && btr && tls[m_cur]) m_sent_last = 1;
    m_prev = xfer;
    @(negedge clk);
  endtask

  task automatic hsk_step(input logic [1:0] t);
    hsk = 1'b1; htype = t; step(); hsk = 1'b0;
  endtask

  task automatic chk_bytes(input string n, input logic [7:0] base);
    for (int k = 0; k < fwd.size() && k < 4; k++) chk(n, fwd[k], base + 8'(k));
  endtask

  // directed corner sequences followed by random traffic
  initial begin
    set_pkt(0, 8'h10); set_pkt(1, 8'h20);
    drive_src();
    #1;
    chk("reset tready", tready, 0); chk("reset tvalid", btv, 0);
    chk("reset commit", commit, 0); chk("reset rewind", rewind, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tv[0] = '{4'd0, 2'b11, 2'b00, 1'b0};
    tv[1] = '{4'd1, 2'b01, 2'b00, 1'b1};
    tv[2] = '{4'd1, 2'b10, 2'b00, 1'b0};
    tv[3] = '{4'd2, 2'b10, 2'b00, 1'b1};
    tv[4] = '{4'd2, 2'b10, 2'b10, 1'b0};
    tv[5] = '{4'd3, 2'b11, 2'b00, 1'b0};
    tv[6] = '{4'd15, 2'b11, 2'b00, 1'b0};
    tv[7] = '{4'd1, 2'b11, 2'b01, 1'b0};
    tv[8] = '{4'd2, 2'b11, 2'b01, 1'b1};
    foreach (tv[i]) begin
      ep = tv[i].ep; has = tv[i].has; halt = tv[i].halt;
      step();
      chk("vec has_data", bhd, tv[i].exp);
    end
    set_pkt(1, 8'hA0); ep = 4'd2; has = 2'b10; halt = 2'b00; btr = 1'b1;
    step(); clr();
    xfer = 1'b1; repeat (6) step();
    hsk_step(2'b00); step(); xfer = 1'b0; step();
    chk("ack beats", beats, 4); chk_bytes("ack byte", 8'hA0);
    chk("ack commits", cmt_cnt, 1); chk("ack rewinds", rew_cnt, 0); chk("ack tready0", rdy0_seen, 0);
    set_pkt(1, 8'hB0); clr();
    xfer = 1'b1; repeat (6) step();
    hsk_step(2'b10); step(); xfer = 1'b0; step();
    chk("nak beats", beats, 4); chk("nak rewinds", rew_cnt, 1); chk("nak commits", cmt_cnt, 0);
    clr();
    xfer = 1'b1; repeat (6) step();
    hsk_step(2'b00); step(); xfer = 1'b0; step();
    chk("retry beats", beats, 4); chk_bytes("retry byte", 8'hB0); chk("retry commits", cmt_cnt, 1);
    set_pkt(1, 8'hC0); clr();
    xfer = 1'b1; repeat (8) step();
    xfer = 1'b0; step(); step();
    chk("timeout rewinds", rew_cnt, 1); chk("timeout commits", cmt_cnt, 0);
    clr(); ep = 4'd5; has = 2'b11;
    xfer = 1'b1; repeat (4) step(); hsk_step(2'b00); xfer = 1'b0; step();
    ep = 4'd2; halt = 2'b10;
    xfer = 1'b1; repeat (4) step(); hsk_step(2'b00); xfer = 1'b0; step();
    hsk_step(2'b11); step(); halt = 2'b00;
    chk("blocked tready", rdy_any, 0); chk("blocked pulses", cmt_cnt + rew_cnt, 0);
    set_pkt(1, 8'hD0); clr(); has = 2'b10;
    xfer = 1'b1; repeat (6) step();
    hsk = 1'b1; htype = 2'b00; xfer = 1'b0; step(); hsk = 1'b0; step(); step();
    chk("hsk+fall commits", cmt_cnt, 1); chk("hsk+fall rewinds", rew_cnt, 0);
    set_pkt(1, 8'hE0); clr();
    xfer = 1'b1; repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("rst tvalid", btv, 0); chk("rst tready", tready, 0);
    chk("rst commit", commit, 0); chk("rst rewind", rewind, 0);
    model_reset();
    @(negedge clk);
    chk("rst hold commit", commit, 0); chk("rst hold rewind", rewind, 0);
    xfer = 1'b0; rst_n = 1'b1;
    step(); step();
    chk("rst beats", beats, 2); chk("rst pulses", cmt_cnt + rew_cnt, 0);
    set_pkt(1, 8'hF0); clr();
    xfer = 1'b1; repeat (6) step(); hsk_step(2'b00); step(); xfer = 1'b0; step();
    chk("post-rst beats", beats, 4); chk("post-rst commits", cmt_cnt, 1);
    set_pkt(1, 8'h50); clr();
    xfer = 1'b1; step(); step(); has = 2'b00;
    repeat (4) step(); hsk_step(2'b00); step(); xfer = 1'b0; step(); has = 2'b10;
    chk("drop beats", beats, 4); chk_bytes("drop byte", 8'h50); chk("drop commits", cmt_cnt, 1);
    new_pkt(0); new_pkt(1); has = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      if (!xfer && $urandom_range(0, 3) == 0) ep = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) xfer = ~xfer;
      hsk = $urandom_range(0, 9) == 0;
      htype = 2'($urandom);
      btr = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) has = 2'($urandom);
      if ($urandom_range(0, 31) == 0) halt = 2'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
